booth_mult_seq: RTL and testbench

//  Parametrised sequential radix-2 Booth multiplier: controller FSM and datapath in one block.

---
 rtl/booth_mult_seq.sv | 111 +++++++++++
 tb/tb_booth_mult_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Sequential radix-2 Booth multiplier, signed or unsigned per op,
//            with a start/busy/done handshake and a held registered product.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
  parameter int W     = 6,
  parameter int CNT_W = $clog2(W+2)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [CNT_W-1:0] c_count_init = CNT_W'(W+1);
  localparam logic [CNT_W-1:0] c_count_one  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [W+1:0]     r_a;
  logic [W+1:0]     r_m;
  logic [W:0]       r_q;
  logic             r_q1;
  logic [CNT_W-1:0] r_count;
  logic [2*W-1:0]   r_product;

  logic [W:0]       w_x_ext;
  logic [W+1:0]     w_y_ext;
  logic [W+1:0]     w_sum;
  logic [W+1:0]     w_a_next;
  logic [W:0]       w_q_next;
  logic             w_q1_next;
  logic [2*W-1:0]   w_product_next;

  // One extra bit on Q and two on M/A keep the most negative signed value and
  // the all-ones unsigned value representable, so the product is always exact.
  assign w_x_ext = {signed_op & x[W-1], x};
  assign w_y_ext = {{2{signed_op & y[W-1]}}, y};

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_next       = {w_sum[W+1], w_sum[W+1:1]};
  assign w_q_next       = {w_sum[0], r_q[W:1]};
  assign w_q1_next      = r_q[0];
  assign w_product_next = {w_a_next[W-2:0], w_q_next};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_a     <= '0;
            r_m     <= w_y_ext;
            r_q     <= w_x_ext;
            r_q1    <= 1'b0;
            r_count <= c_count_init;
            r_state <= c_st_calc;
          end
        end
        c_st_calc: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_q1    <= w_q1_next;
          r_count <= r_count - c_count_one;
          if (r_count == c_count_one) begin
            r_product <= w_product_next;
            r_state   <= c_st_done;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign busy    = (r_state == c_st_calc);
  assign done    = (r_state == c_st_done);
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_seq
// Brief    : Self-checking bench for booth_mult_seq (W=6) with a product queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

  localparam int W = 6;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mult_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mult(input logic sgn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [2*W-1:0] ae;
    logic [2*W-1:0] be;
    ae = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ae * be;
  endfunction

  // Compare the current product against the oldest queued expectation.
  task automatic pop_and_check(input string name);
    logic [2*W-1:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, queue empty", name, product);
    end else begin
      exp_v = exp_q.pop_front();
      if (product !== exp_v) begin
        errors++;
        $display("FAIL %s: got %h want %h", name, product, exp_v);
      end
    end
  endtask

  // Launch one operation, optionally scramble inputs while busy, then check
  // latency, product stability during CALC, the result and the done pulse width.
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_v,
                        input bit scramble);
    int n;
    int nbusy;
    bit moved;
    logic [2*W-1:0] prev;
    @(negedge clk);
    prev      = product;
    start     = 1'b1;
    signed_op = sgn;
    x         = a;
    y         = b;
    exp_q.push_back(exp_v);
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      x         = W'($urandom);
      y         = W'($urandom);
      signed_op = ~sgn;
    end
    n = 0; nbusy = 0; moved = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nbusy++;
      if (product !== prev) moved = 1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, n);
      void'(exp_q.pop_front());
      return;
    end
    pop_and_check(name);
    checks++;
    if (nbusy != W+1) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d want %0d", name, nbusy, W+1);
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL %s_stable: product moved while busy, got 1 want 0", name);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h want 0 0 000", busy, done, product);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_signed();
    run_op("s_m32_m32", 1'b1, 6'h20, 6'h20, 12'h400, 1'b0);
    run_op("s_31_m32",  1'b1, 6'h1F, 6'h20, 12'hC20, 1'b0);
    run_op("s_0_m5",    1'b1, 6'h00, 6'h3B, 12'h000, 1'b0);
    run_op("s_m1_1",    1'b1, 6'h3F, 6'h01, 12'hFFF, 1'b0);
  endtask

  task automatic test_unsigned();
    run_op("u_63_63", 1'b0, 6'h3F, 6'h3F, 12'hF81, 1'b0);
    run_op("u_32_2",  1'b0, 6'h20, 6'h02, 12'h040, 1'b0);
    run_op("u_63_1",  1'b0, 6'h3F, 6'h01, 12'h03F, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa[3] = '{6'h05, 6'h3F, 6'h20};
    logic [W-1:0] ya[3] = '{6'h07, 6'h3F, 6'h3F};
    logic         sa[3] = '{1'b0, 1'b1, 1'b0};
    int n;
    @(negedge clk);
    start = 1'b1; signed_op = sa[0]; x = xa[0]; y = ya[0];
    exp_q.push_back(ref_mult(sa[0], xa[0], ya[0]));
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 40);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL b2b_timeout: pair %0d done=%b want 1", k, done);
        start = 1'b0;
        exp_q.delete();
        return;
      end
      pop_and_check($sformatf("b2b_pair%0d", k));
      if (k > 0) begin
        checks++;
        if (n != W+3) begin
          errors++;
          $display("FAIL b2b_interval: pair %0d got %0d want %0d", k, n, W+3);
        end
      end
      if (k < 2) begin
        signed_op = sa[k+1]; x = xa[k+1]; y = ya[k+1];
        exp_q.push_back(ref_mult(sa[k+1], xa[k+1], ya[k+1]));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit saw_done;
    run_op("pre_abort", 1'b0, 6'h15, 6'h2A, 12'h372, 1'b0);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; x = 6'h11; y = 6'h23;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b product=%h want 0 0 000", busy, done, product);
    end
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: activity after abort got 1 want 0");
    end
    run_op("post_abort", 1'b1, 6'h11, 6'h23, ref_mult(1'b1, 6'h11, 6'h23), 1'b0);
  endtask

  task automatic test_random();
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 300; i++) begin
      sgn = 1'($urandom);
      a   = (i % 10 == 0) ? 6'h20 : W'($urandom);
      b   = (i % 7 == 0)  ? 6'h3F : W'($urandom);
      run_op("random", sgn, a, b, ref_mult(sgn, a, b), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
